// File: rtl/cpu_pkg.sv
// Shared decode constants, resolver FSM state encoding and the JMP jump table.
// Latency: n/a (constants only).  Backpressure: n/a.
package cpu_pkg;

    localparam logic [2:0] OP_SYS   = 3'b101;
    localparam logic [2:0] OP_BZ    = 3'b110;
    localparam logic [2:0] OP_JMP   = 3'b111;
    localparam logic [5:0] HALT_IMM = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SQUASH = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    localparam int JT_DEPTH = 16;
    localparam int JT_W     = 16;

    // Entry i sits at i*0x20 so each jump lands on a distinct 32-word block.
    localparam logic [JT_W-1:0] JT [JT_DEPTH] = '{
        16'h0000, 16'h0020, 16'h0040, 16'h0060,
        16'h0080, 16'h00A0, 16'h00C0, 16'h00E0,
        16'h0100, 16'h0120, 16'h0140, 16'h0160,
        16'h0180, 16'h01A0, 16'h01C0, 16'h01E0
    };

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch <-> decode-stage branch bus: fetched instruction in, resolution pulses back.
// Latency: n/a (wiring).  Backpressure: none; fetch side presents one slot per cycle.
interface branch_resolver_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 9
);
    logic               instr_valid;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc;
    logic               cond_flag;
    logic               branch;
    logic               taken;
    logic [PC_W-1:0]    target;
    logic               squash;
    logic               halted;

    modport master (
        output instr_valid, instruction, pc, cond_flag,
        input  branch, taken, target, squash, halted
    );

    modport slave (
        input  instr_valid, instruction, pc, cond_flag,
        output branch, taken, target, squash, halted
    );
endinterface

// File: rtl/branch_target_lut.sv
// Combinational jump-table ROM returning the JMP destination for a 4-bit index.
// Latency: 0 cycles.  Backpressure: none.
module branch_target_lut
    import cpu_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int LUT_DEPTH = 16
) (
    input  logic [$clog2(LUT_DEPTH)-1:0] idx,
    output logic [PC_W-1:0]              target
);

    always_comb begin
        target = PC_W'(JT[idx]);
    end

endmodule

// File: rtl/branch_resolver.sv
// Decode-stage branch resolver: BZ/JMP/HALT decode, target compute, wrong-path squash.
// Latency: 1 cycle instruction -> branch/taken/target; squash follows taken by 1 cycle.
// Backpressure: none; optional BRANCH_RESOLVER_STATS_EN adds saturating branch/taken counters.
module branch_resolver
    import cpu_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int INSTR_W   = 9,
    parameter int LUT_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    branch_resolver_if.slave   bus
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [15:0]        branch_count,
    output logic [15:0]        taken_count
`endif
);

    state_e          state_q;
    logic            branch_q;
    logic            taken_q;
    logic [PC_W-1:0] target_q;
    logic            squash_q;
    logic            halted_q;

    logic [2:0]      op;
    logic [5:0]      imm;
    logic            is_bz;
    logic            is_jmp;
    logic            is_halt;
    logic            resolve;
    logic [PC_W-1:0] bz_target;
    logic [PC_W-1:0] jmp_target;

    always_comb begin
        op        = bus.instruction[8:6];
        imm       = bus.instruction[5:0];
        is_bz     = (op == OP_BZ);
        is_jmp    = (op == OP_JMP);
        is_halt   = (op == OP_SYS) && (imm == HALT_IMM);
        // start wins over any decode result in the same cycle
        resolve   = (state_q == ST_RUN) && bus.instr_valid && !start;
        bz_target = bus.pc + {{(PC_W-6){imm[5]}}, imm};
    end

    branch_target_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_lut (
        .idx    (bus.instruction[$clog2(LUT_DEPTH)-1:0]),
        .target (jmp_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            branch_q <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            squash_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            branch_q <= 1'b0;
            taken_q  <= 1'b0;
            squash_q <= 1'b0;
            if (start) begin
                state_q  <= ST_RUN;
                halted_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (resolve && is_bz) begin
                            branch_q <= 1'b1;
                            taken_q  <= bus.cond_flag;
                            target_q <= bz_target;
                            if (bus.cond_flag) state_q <= ST_SQUASH;
                        end else if (resolve && is_jmp) begin
                            branch_q <= 1'b1;
                            taken_q  <= 1'b1;
                            target_q <= jmp_target;
                            state_q  <= ST_SQUASH;
                        end else if (resolve && is_halt) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                    end
                    ST_SQUASH: begin
                        squash_q <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.branch = branch_q;
    assign bus.taken  = taken_q;
    assign bus.target = target_q;
    assign bus.squash = squash_q;
    assign bus.halted = halted_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic res_branch;
    logic res_taken;

    always_comb begin
        res_branch = resolve && (is_bz || is_jmp);
        res_taken  = resolve && (is_jmp || (is_bz && bus.cond_flag));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (start) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            if (res_branch && (branch_count != 16'hFFFF)) branch_count <= branch_count + 16'd1;
            if (res_taken  && (taken_count  != 16'hFFFF)) taken_count  <= taken_count  + 16'd1;
        end
    end
`endif

endmodule
